mem_request_stage: RTL

//  Execute->memory pipeline boundary for the 3-stage RISC-V core. Registers execute results

---
 rtl/mem_request_stage_pkg.sv | 44 ++++
 rtl/mem_request_stage_if.sv | 26 ++
 rtl/mem_request_stage_store_align.sv | 34 +++
 rtl/mem_request_stage.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mem_request_stage_pkg.sv
// mem_stage_pkg: shared encodings for the execute->memory pipeline boundary.
//   - access size codes (funct3[1:0])
//   - request-stage FSM encodings
//   - writeback select and load select codes shared with the writeback stage
//   - is_misaligned(): address/size alignment test used when misaligned
//     accesses are trapped instead of issued
package mem_stage_pkg;

  // Access size, taken straight from funct3[1:0]; 2'b11 behaves as a word.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Request-stage FSM encodings.
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] WAIT_R = 2'd2;

  // Writeback source select.
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_DMEM = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  // Load extension select (funct3 of the load), consumed by writeback.
  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  // Bytes never misalign; halves need a[0]==0; words need a[1:0]==0.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_request_stage_if.sv
// mem_request_stage_if: data-memory / MMIO request bus.
//   req    stage -> mem  request valid
//   addr   stage -> mem  word-aligned byte address
//   we     stage -> mem  byte enables, 4'b0000 = read
//   wdata  stage -> mem  lane-aligned store data
//   gnt    mem -> stage  request accepted this cycle
//   rvalid mem -> stage  read data valid this cycle
//   rdata  mem -> stage  read data
//
// Handshake: req is a valid that, once raised, holds addr/we/wdata stable
// until the cycle gnt is sampled high (gnt is the ready); that cycle is the
// transfer. For reads, rvalid may arrive in the grant cycle or any later
// cycle, and each transfer returns exactly one rvalid. gnt and rvalid are
// only meaningful while a request is outstanding.
interface mem_request_stage_if;
  logic        req;
  logic [31:0] addr;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, we, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_request_stage_store_align.sv
// store_align: combinational store lane placement.
//   size    in  2   access size code (SZ_B/SZ_H/SZ_W, 2'b11 = word)
//   addr_lo in  2   effective address bits [1:0]
//   wdata   in  32  rs2 store data
//   we      out 4   byte enables for the word-aligned bus
//   lane    out 32  store data replicated onto every candidate lane
// Halves use only addr_lo[1]; words ignore addr_lo entirely.
module store_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  we,
  output logic [31:0] lane
);

  always_comb begin
    we   = 4'b1111;
    lane = wdata;
    case (size)
      SZ_B: begin
        we   = 4'b0001 << addr_lo;
        lane = {4{wdata[7:0]}};
      end
      SZ_H: begin
        we   = 4'b0011 << {addr_lo[1], 1'b0};
        lane = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_request_stage.sv
// mem_request_stage: execute->memory pipeline boundary of the 3-stage core.
// Registers the execute bundle into the writeback bundle and runs the
// data-memory transaction over mem_request_stage_if, stalling execute
// (ex_ready=0) while an access is outstanding.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   ex_valid/ex_mem_rd/ex_mem_wr/ex_size/ex_addr/ex_wdata/ex_pc/ex_inst/
//   ex_ldsel/ex_wbsel        execute bundle in
//   ex_ready                stage accepts the bundle this cycle
//   mem                     request bus (master side)
//   wb_valid + wb_*         writeback bundle, wb_valid is a one-cycle pulse
//   bus_err                 one-cycle pulse when a load times out
//   misalign_err            (MEM_MISALIGN_TRAP_EN only) one-cycle pulse when a
//                           misaligned access is trapped instead of issued
//   dbg_state               current FSM state
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN.
module mem_request_stage
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_mem_rd,
  input  logic        ex_mem_wr,
  input  logic [1:0]  ex_size,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_inst,
  input  logic [2:0]  ex_ldsel,
  input  logic [1:0]  ex_wbsel,
  output logic        ex_ready,
  mem_request_stage_if.master mem,
  output logic        wb_valid,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_alu,
  output logic [31:0] wb_inst,
  output logic [31:0] wb_rdata,
  output logic [2:0]  wb_ldsel,
  output logic [1:0]  wb_wbsel,
  output logic        bus_err,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        misalign_err,
`endif
  output logic [1:0]  dbg_state
);

  logic [1:0]       state;
  logic             is_store_q;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      addr_q;
  logic [3:0]       we_q;
  logic [31:0]      wdata_q;

  logic [3:0]       al_we;
  logic [31:0]      al_lane;
  logic             accept;
  logic             is_mem;
  logic             timeout;

  store_align u_store_align (
    .size    (ex_size),
    .addr_lo (ex_addr[1:0]),
    .wdata   (ex_wdata),
    .we      (al_we),
    .lane    (al_lane)
  );

  assign ex_ready  = (state == IDLE);
  assign accept    = ex_valid && ex_ready;
  assign is_mem    = ex_mem_rd || ex_mem_wr;
  // cnt holds the WAIT_R cycles already elapsed, so this is the cycle that
  // brings the wait to MAX_WAIT.
  assign timeout   = (cnt == CNT_W'(MAX_WAIT - 1));
  assign dbg_state = state;

  // mem_req is decoded from state so it drops the instant reset asserts.
  assign mem.req   = (state == REQ);
  assign mem.addr  = addr_q;
  assign mem.we    = we_q;
  assign mem.wdata = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      is_store_q <= 1'b0;
      cnt        <= '0;
      addr_q     <= '0;
      we_q       <= '0;
      wdata_q    <= '0;
      wb_valid   <= 1'b0;
      wb_pc      <= '0;
      wb_alu     <= '0;
      wb_inst    <= '0;
      wb_rdata   <= '0;
      wb_ldsel   <= '0;
      wb_wbsel   <= '0;
      bus_err    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_err <= 1'b0;
`endif
    end else begin
      wb_valid <= 1'b0;
      bus_err  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            wb_pc    <= ex_pc;
            wb_alu   <= ex_addr;
            wb_inst  <= ex_inst;
            wb_ldsel <= ex_ldsel;
            wb_wbsel <= ex_wbsel;
            if (!is_mem) begin
              wb_valid <= 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
            end else if (is_misaligned(ex_size, ex_addr[1:0])) begin
              wb_valid     <= 1'b1;
              misalign_err <= 1'b1;
              wb_rdata     <= '0;
              we_q         <= '0;
`endif
            end else begin
              // A bundle with both rd and wr set is treated as a store.
              addr_q     <= {ex_addr[31:2], 2'b00};
              is_store_q <= ex_mem_wr;
              we_q       <= ex_mem_wr ? al_we : 4'b0000;
              wdata_q    <= al_lane;
              state      <= REQ;
            end
          end
        end
        REQ: begin
          if (mem.gnt) begin
            // Byte enables return to zero once the request is taken.
            we_q <= '0;
            if (is_store_q) begin
              wb_valid <= 1'b1;
              state    <= IDLE;
            end else if (mem.rvalid) begin
              wb_rdata <= mem.rdata;
              wb_valid <= 1'b1;
              state    <= IDLE;
            end else begin
              cnt   <= '0;
              state <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          // Data arriving on the timeout cycle still completes normally.
          if (mem.rvalid) begin
            wb_rdata <= mem.rdata;
            wb_valid <= 1'b1;
            state    <= IDLE;
          end else if (timeout) begin
            wb_rdata <= '0;
            wb_valid <= 1'b1;
            bus_err  <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
